// File: rtl/eth_capture_ring.sv
// eth_capture_ring: slot-ring controller for the Ethernet capture DMA path.
// Grants fixed-size SRAM buffer slots to the capture engine, records the
// committed length of each packet and presents completed slots to the host
// in FIFO order until released. Refused requests are counted (saturating).
// Optional feature macro: ETH_CAPTURE_RING_IRQ_EN (commit interrupt pulse).
module eth_capture_ring #(
    parameter int          SLOT_COUNT = 8,
    parameter int          SLOT_BYTES = 2048,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          cap_req,
    output logic                          cap_grant,
    output logic                          cap_drop,
    output logic [31:0]                   cap_addr,
    input  logic                          cap_done,
    input  logic                          cap_err,
    input  logic [11:0]                   cap_len,
    output logic                          host_valid,
    output logic [$clog2(SLOT_COUNT)-1:0] host_slot,
    output logic [11:0]                   host_len,
    input  logic                          host_ack,
    output logic [15:0]                   drop_count,
    output logic                          irq
);

    localparam int          SW      = $clog2(SLOT_COUNT);
    localparam int          SB      = $clog2(SLOT_BYTES);
    localparam logic [12:0] LEN_MAX = 13'(SLOT_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [SW:0]   wr_ptr_q, wr_ptr_d;
    logic [SW:0]   rd_ptr_q, rd_ptr_d;
    logic          cap_grant_q, cap_grant_d;
    logic          cap_drop_q, cap_drop_d;
    logic [31:0]   cap_addr_q, cap_addr_d;
    logic          host_valid_q, host_valid_d;
    logic [SW-1:0] host_slot_q, host_slot_d;
    logic [11:0]   host_len_q, host_len_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic [11:0]   len_mem [SLOT_COUNT];

    logic [SW:0]   count;
    logic          full;
    logic          commit;
    logic          drop_inc;
    logic [11:0]   len_clamped;

    // Ring occupancy and the length clamp (lengths never exceed one slot).
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        full        = (count == (SW+1)'(SLOT_COUNT));
        len_clamped = ({1'b0, cap_len} > LEN_MAX) ? LEN_MAX[11:0] : cap_len;
    end

    // Next-state logic: grant/drop FSM, pointer updates and host view.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cap_grant_d  = 1'b0;
        cap_addr_d   = cap_addr_q;
        commit       = 1'b0;
        drop_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cap_req) begin
                    if (enable && !full) begin
                        cap_grant_d = 1'b1;
                        cap_addr_d  = BASE_ADDR + (32'(wr_ptr_q[SW-1:0]) << SB);
                        state_d     = BUSY;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            BUSY: begin
                // A second request mid-packet is an engine protocol error;
                // refuse it without disturbing the slot in flight.
                if (cap_req) begin
                    drop_inc = 1'b1;
                end
                if (cap_done) begin
                    commit  = !cap_err;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (host_ack && (count != '0)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        cap_drop_d   = drop_inc;
        drop_count_d = (drop_inc && (drop_count_q != 16'hFFFF)) ? drop_count_q + 16'd1
                                                                : drop_count_q;

        // The host view after this cycle's commit/ack. When the oldest
        // pending slot is the one being committed right now, forward the
        // incoming length since the table write lands on this same edge.
        host_valid_d = (wr_ptr_d != rd_ptr_d);
        host_slot_d  = rd_ptr_d[SW-1:0];
        if (!host_valid_d) begin
            host_len_d = 12'd0;
        end else if (commit && (rd_ptr_d[SW-1:0] == wr_ptr_q[SW-1:0])) begin
            host_len_d = len_clamped;
        end else begin
            host_len_d = len_mem[rd_ptr_d[SW-1:0]];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cap_grant_q  <= 1'b0;
            cap_drop_q   <= 1'b0;
            cap_addr_q   <= BASE_ADDR;
            host_valid_q <= 1'b0;
            host_slot_q  <= '0;
            host_len_q   <= 12'd0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cap_grant_q  <= cap_grant_d;
            cap_drop_q   <= cap_drop_d;
            cap_addr_q   <= cap_addr_d;
            host_valid_q <= host_valid_d;
            host_slot_q  <= host_slot_d;
            host_len_q   <= host_len_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Length table; contents are only meaningful behind valid pointers,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            len_mem[wr_ptr_q[SW-1:0]] <= len_clamped;
        end
    end

`ifdef ETH_CAPTURE_RING_IRQ_EN
    logic irq_q, irq_d;

    // Commit interrupt: one pulse per successfully committed packet.
    always_comb begin
        irq_d = commit;
    end

    // Interrupt register.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign cap_grant  = cap_grant_q;
    assign cap_drop   = cap_drop_q;
    assign cap_addr   = cap_addr_q;
    assign host_valid = host_valid_q;
    assign host_slot  = host_slot_q;
    assign host_len   = host_len_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_eth_capture_ring.sv
// Directed testbench for eth_capture_ring (SLOT_COUNT=8, SLOT_BYTES=2048,
// BASE_ADDR=0x1000_0000). Irq expectations follow ETH_CAPTURE_RING_IRQ_EN.
module tb_eth_capture_ring;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef ETH_CAPTURE_RING_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable, cap_req, cap_done, cap_err, host_ack;
    logic [11:0] cap_len;
    logic        cap_grant, cap_drop, host_valid, irq;
    logic [31:0] cap_addr;
    logic [2:0]  host_slot;
    logic [11:0] host_len;
    logic [15:0] drop_count;

    int check_count = 0;
    int pass_count  = 0;
    int grants_seen;

    eth_capture_ring #(
        .SLOT_COUNT (8),
        .SLOT_BYTES (2048),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cap_req    (cap_req),
        .cap_grant  (cap_grant),
        .cap_drop   (cap_drop),
        .cap_addr   (cap_addr),
        .cap_done   (cap_done),
        .cap_err    (cap_err),
        .cap_len    (cap_len),
        .host_valid (host_valid),
        .host_slot  (host_slot),
        .host_len   (host_len),
        .host_ack   (host_ack),
        .drop_count (drop_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
            $display("check %s ok: 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are examined 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        cap_req  = 1'b0;
        cap_done = 1'b0;
        cap_err  = 1'b0;
        cap_len  = 12'd0;
        host_ack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic request();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
    endtask

    task automatic finish_pkt(input logic [11:0] len, input logic err);
        cap_done = 1'b1;
        cap_err  = err;
        cap_len  = len;
        tick();
        cap_done = 1'b0;
        cap_err  = 1'b0;
    endtask

    task automatic ack();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_grant"}, 32'(cap_grant), 32'd0);
        check({pfx, "_drop"},  32'(cap_drop),  32'd0);
        check({pfx, "_addr"},  cap_addr,       BASE);
        check({pfx, "_valid"}, 32'(host_valid), 32'd0);
        check({pfx, "_slot"},  32'(host_slot), 32'd0);
        check({pfx, "_len"},   32'(host_len),  32'd0);
        check({pfx, "_dcnt"},  32'(drop_count), 32'd0);
        check({pfx, "_irq"},   32'(irq),       32'd0);
    endtask

    initial begin
        enable = 1'b1;
        do_reset();
        check_reset_state("rst");

        // First packet: grant at slot 0, commit length 277.
        request();
        check("s1_grant", 32'(cap_grant), 32'd1);
        check("s1_nodrop", 32'(cap_drop), 32'd0);
        check("s1_addr", cap_addr, BASE);
        finish_pkt(12'd277, 1'b0);
        check("s1_valid", 32'(host_valid), 32'd1);
        check("s1_slot", 32'(host_slot), 32'd0);
        check("s1_len", 32'(host_len), 32'd277);
        check("s1_irq", 32'(irq), 32'(IRQ_ON));
        tick();
        check("s1_irq_off", 32'(irq), 32'd0);

        // Fill all eight slots without acking.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            request();
            check($sformatf("fill_grant%0d", i), 32'(cap_grant), 32'd1);
            check($sformatf("fill_addr%0d", i), cap_addr, BASE + 32'(i) * 32'h800);
            finish_pkt(12'(100 + i), 1'b0);
        end
        check("full_valid", 32'(host_valid), 32'd1);
        check("full_slot", 32'(host_slot), 32'd0);
        check("full_len", 32'(host_len), 32'd100);
        request();
        check("full_drop", 32'(cap_drop), 32'd1);
        check("full_nogrant", 32'(cap_grant), 32'd0);
        check("full_dcnt1", 32'(drop_count), 32'd1);
        // Ack in the same cycle as a request does not free a slot for it.
        cap_req  = 1'b1;
        host_ack = 1'b1;
        tick();
        cap_req  = 1'b0;
        host_ack = 1'b0;
        check("ackreq_drop", 32'(cap_drop), 32'd1);
        check("ackreq_dcnt2", 32'(drop_count), 32'd2);
        check("ackreq_slot", 32'(host_slot), 32'd1);
        check("ackreq_len", 32'(host_len), 32'd101);
        request();
        check("wrap_grant", 32'(cap_grant), 32'd1);
        check("wrap_addr", cap_addr, BASE);
        finish_pkt(12'd3000, 1'b0);
        for (int k = 1; k < 8; k++) begin
            check($sformatf("drain_slot%0d", k), 32'(host_slot), 32'(k));
            check($sformatf("drain_len%0d", k), 32'(host_len), 32'(100 + k));
            ack();
        end
        check("clamp_slot", 32'(host_slot), 32'd0);
        check("clamp_len", 32'(host_len), 32'd2048);
        ack();
        check("drain_empty", 32'(host_valid), 32'd0);

        // Errored packet is discarded and its slot reused.
        do_reset();
        request();
        check("err_addr", cap_addr, BASE);
        finish_pkt(12'd64, 1'b1);
        check("err_valid", 32'(host_valid), 32'd0);
        check("err_irq", 32'(irq), 32'd0);
        request();
        check("err_regrant", 32'(cap_grant), 32'd1);
        check("err_reuse_addr", cap_addr, BASE);
        finish_pkt(12'd10, 1'b0);
        check("err_ok_valid", 32'(host_valid), 32'd1);
        check("err_ok_len", 32'(host_len), 32'd10);

        // Commit and ack together with a single slot pending.
        request();
        check("ca_addr", cap_addr, BASE + 32'h800);
        cap_done = 1'b1;
        cap_len  = 12'd20;
        host_ack = 1'b1;
        tick();
        cap_done = 1'b0;
        host_ack = 1'b0;
        check("ca_valid", 32'(host_valid), 32'd1);
        check("ca_slot", 32'(host_slot), 32'd1);
        check("ca_len", 32'(host_len), 32'd20);
        ack();
        check("ca_empty", 32'(host_valid), 32'd0);

        // Request during BUSY is dropped; enable falling mid-packet still commits.
        request();
        check("busy_grant", 32'(cap_grant), 32'd1);
        check("busy_addr", cap_addr, BASE + 32'h1000);
        request();
        check("busy_drop", 32'(cap_drop), 32'd1);
        check("busy_nogrant", 32'(cap_grant), 32'd0);
        check("busy_dcnt", 32'(drop_count), 32'd1);
        enable = 1'b0;
        finish_pkt(12'd30, 1'b0);
        enable = 1'b1;
        check("en_fall_valid", 32'(host_valid), 32'd1);
        check("en_fall_slot", 32'(host_slot), 32'd2);
        check("en_fall_len", 32'(host_len), 32'd30);

        // Reset while BUSY.
        request();
        check("rb_grant", 32'(cap_grant), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("rb");
        finish_pkt(12'd40, 1'b0);
        check("rb_done_ignored", 32'(host_valid), 32'd0);
        request();
        check("rb_regrant", 32'(cap_grant), 32'd1);
        check("rb_addr", cap_addr, BASE);

        // Disabled capture: every request dropped, counter saturates.
        do_reset();
        enable      = 1'b0;
        grants_seen = 0;
        cap_req     = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            tick();
            if (cap_grant) grants_seen++;
        end
        cap_req = 1'b0;
        check("dis_nogrants", 32'(grants_seen), 32'd0);
        check("dis_dcnt_sat", 32'(drop_count), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
